owt_rx_frame_ctrl: RTL and testbench

Frame-level receive sequencer placed after the OWT-mode symbol detector. It consumes detected symbol strobes and symbol values, hunts for a preamble, assembles a fixed-width data word, and checks even parity. It enforces an inter-symbol timeout and reports one frame result per received frame, or per abort, to the register/control layer.

---
 rtl/owt_rx_frame_ctrl.sv | 135 +++++++++++++
 tb/tb_owt_rx_frame_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/owt_rx_frame_ctrl.sv
// Frame-level receive sequencer: preamble hunt, MSB-first payload assembly,
// even-parity check and inter-symbol timeout, one result pulse per frame or abort.
module owt_rx_frame_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                SYNC_LEN = 4,
    parameter int                TMO_W    = 12,
    parameter logic [TMO_W-1:0]  TMO_TH   = TMO_W'(2000)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_sym_vld,
    input  logic              i_sym_data,
    output logic              o_frm_vld,
    output logic [DATA_W-1:0] o_frm_data,
    output logic [1:0]        o_frm_err,
    output logic              o_busy
);

    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int ONES_W = $clog2(SYNC_LEN + 1);

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_PARITY = 2'd1;
    localparam logic [1:0] ERR_TMO    = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } state_t;

    state_t              state_reg;
    logic [ONES_W-1:0]   ones_cnt_reg;
    logic [BIT_W-1:0]    bit_cnt_reg;
    logic [TMO_W-1:0]    gap_cnt_reg;
    logic [DATA_W-1:0]   shreg_reg;
    logic                frm_vld_reg;
    logic [DATA_W-1:0]   frm_data_reg;
    logic [1:0]          frm_err_reg;
    logic                busy_reg;

    // Even parity across payload and parity bit: any odd total is an error.
    logic perr;
    assign perr = i_sym_data ^ (^shreg_reg);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            ones_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            shreg_reg    <= '0;
            frm_vld_reg  <= 1'b0;
            frm_data_reg <= '0;
            frm_err_reg  <= ERR_OK;
            busy_reg     <= 1'b0;
        end else begin
            frm_vld_reg <= 1'b0;
            if (!i_en) begin
                // Enable dominates every other event: drop the frame silently.
                state_reg    <= IDLE;
                busy_reg     <= 1'b0;
                ones_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
                gap_cnt_reg  <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg    <= SYNC;
                        ones_cnt_reg <= '0;
                    end
                    SYNC: begin
                        if (i_sym_vld) begin
                            if (i_sym_data) begin
                                if (ones_cnt_reg < ONES_W'(SYNC_LEN))
                                    ones_cnt_reg <= ones_cnt_reg + ONES_W'(1);
                            end else if (ones_cnt_reg >= ONES_W'(SYNC_LEN)) begin
                                // Start bit: consumed here, never stored.
                                state_reg   <= DATA;
                                busy_reg    <= 1'b1;
                                bit_cnt_reg <= '0;
                                gap_cnt_reg <= '0;
                                shreg_reg   <= '0;
                            end else begin
                                ones_cnt_reg <= '0;
                            end
                        end
                    end
                    DATA, PARITY: begin
                        if (i_sym_vld) begin
                            gap_cnt_reg <= '0;
                            if (state_reg == DATA) begin
                                shreg_reg   <= {shreg_reg[DATA_W-2:0], i_sym_data};
                                bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                                if (bit_cnt_reg == BIT_W'(DATA_W - 1))
                                    state_reg <= PARITY;
                            end else begin
                                frm_vld_reg  <= 1'b1;
                                frm_data_reg <= shreg_reg;
                                frm_err_reg  <= perr ? ERR_PARITY : ERR_OK;
                                state_reg    <= SYNC;
                                busy_reg     <= 1'b0;
                                ones_cnt_reg <= '0;
                            end
                        end else if (gap_cnt_reg == TMO_TH - TMO_W'(1)) begin
                            // Gap reaches the threshold this edge; a symbol on
                            // this same edge would have taken the branch above.
                            gap_cnt_reg  <= TMO_TH;
                            frm_vld_reg  <= 1'b1;
                            frm_data_reg <= shreg_reg;
                            frm_err_reg  <= ERR_TMO;
                            state_reg    <= SYNC;
                            busy_reg     <= 1'b0;
                            ones_cnt_reg <= '0;
                        end else if (gap_cnt_reg < TMO_TH) begin
                            gap_cnt_reg <= gap_cnt_reg + TMO_W'(1);
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_frm_vld  = frm_vld_reg;
    assign o_frm_data = frm_data_reg;
    assign o_frm_err  = frm_err_reg;
    assign o_busy     = busy_reg;

endmodule

// File: tb/tb_owt_rx_frame_ctrl.sv
// Directed bench for owt_rx_frame_ctrl: clean, parity-error, short-preamble,
// timeout, symbol-at-threshold, enable-abort and reset-abort frames.
module tb_owt_rx_frame_ctrl;

    localparam int DATA_W = 16;

    logic              i_clk;
    logic              i_rst;
    logic              i_en;
    logic              i_sym_vld;
    logic              i_sym_data;
    logic              o_frm_vld;
    logic [DATA_W-1:0] o_frm_data;
    logic [1:0]        o_frm_err;
    logic              o_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;

    owt_rx_frame_ctrl #(
        .DATA_W   (DATA_W),
        .SYNC_LEN (4),
        .TMO_W    (12),
        .TMO_TH   (12'd20)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_sym_vld  (i_sym_vld),
        .i_sym_data (i_sym_data),
        .o_frm_vld  (o_frm_vld),
        .o_frm_data (o_frm_data),
        .o_frm_err  (o_frm_err),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Pre-edge sample: counts every cycle in which o_frm_vld was high.
    always @(posedge i_clk) if (o_frm_vld) vld_cnt++;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    // Called at a negedge; the strobe is captured by the next posedge.
    task automatic sym(input logic b);
        i_sym_vld  = 1'b1;
        i_sym_data = b;
        @(negedge i_clk);
        i_sym_vld  = 1'b0;
        i_sym_data = 1'b0;
    endtask

    task automatic send_preamble();
        repeat (4) sym(1'b1);
        sym(1'b0);
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) sym(w[i]);
    endtask

    // Call straight after the parity symbol: pulse must be high now, then drop.
    task automatic expect_frame(input string tag, input logic [15:0] exp_data, input logic [1:0] exp_err);
        check_val({tag, "_vld"},  32'(o_frm_vld), 32'd1);
        check_val({tag, "_data"}, 32'(o_frm_data), 32'(exp_data));
        check_val({tag, "_err"},  32'(o_frm_err), 32'(exp_err));
        @(negedge i_clk);
        check_val({tag, "_vld_drop"}, 32'(o_frm_vld), 32'd0);
        check_val({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        i_rst = 1'b1;
        i_en = 1'b0;
        i_sym_vld = 1'b0;
        i_sym_data = 1'b0;
        repeat (3) @(negedge i_clk);
        check_val("rst_vld",  32'(o_frm_vld), 32'd0);
        check_val("rst_data", 32'(o_frm_data), 32'd0);
        check_val("rst_err",  32'(o_frm_err), 32'd0);
        check_val("rst_busy", 32'(o_busy), 32'd0);
        i_rst = 1'b0;
        i_en  = 1'b1;
        repeat (2) @(negedge i_clk);

        // Clean frame 0xA5C3 (popcount 8) with parity 0.
        send_preamble();
        check_val("clean_busy_data", 32'(o_busy), 32'd1);
        send_bits(16'hA5C3, 16);
        check_val("clean_busy_par", 32'(o_busy), 32'd1);
        check_val("clean_no_early_vld", 32'(o_frm_vld), 32'd0);
        sym(1'b0);
        expect_frame("clean", 16'hA5C3, 2'd0);

        // Same payload, parity 1 makes the total odd.
        send_preamble();
        send_bits(16'hA5C3, 16);
        sym(1'b1);
        expect_frame("perr", 16'hA5C3, 2'd1);

        // Three ones then zero is rejected; second preamble aligns.
        repeat (3) sym(1'b1);
        sym(1'b0);
        check_val("short_pre_busy", 32'(o_busy), 32'd0);
        send_preamble();
        send_bits(16'h0001, 16);
        sym(1'b1);
        expect_frame("short_pre", 16'h0001, 2'd0);

        // Timeout after 5 bits 10110: pulse 20 edges after the last symbol.
        send_preamble();
        send_bits(16'h0016, 5);
        repeat (19) @(negedge i_clk);
        check_val("tmo_gap19_vld",  32'(o_frm_vld), 32'd0);
        check_val("tmo_gap19_busy", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        check_val("tmo_vld",  32'(o_frm_vld), 32'd1);
        check_val("tmo_err",  32'(o_frm_err), 32'd2);
        check_val("tmo_data", 32'(o_frm_data), 32'h0016);
        check_val("tmo_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        check_val("tmo_vld_drop", 32'(o_frm_vld), 32'd0);
        check_val("tmo_hold_err", 32'(o_frm_err), 32'd2);

        // Symbol landing on the threshold edge wins; frame 0xB400 completes.
        send_preamble();
        send_bits(16'h0016, 5);
        repeat (19) @(negedge i_clk);
        sym(1'b1);
        check_val("edge_sym_no_tmo", 32'(o_frm_vld), 32'd0);
        check_val("edge_sym_busy",   32'(o_busy), 32'd1);
        send_bits(16'h0000, 10);
        sym(1'b0);
        expect_frame("edge_sym", 16'hB400, 2'd0);

        // Drop enable mid-DATA: no pulse, not busy.
        send_preamble();
        send_bits(16'h00AB, 8);
        v0 = vld_cnt;
        i_en = 1'b0;
        @(negedge i_clk);
        check_val("abort_busy", 32'(o_busy), 32'd0);
        send_bits(16'h00FF, 8);
        sym(1'b0);
        repeat (25) @(negedge i_clk);
        check_val("abort_no_vld", 32'(vld_cnt), 32'(v0));
        check_val("abort_busy_idle", 32'(o_busy), 32'd0);
        check_val("abort_hold_data", 32'(o_frm_data), 32'hB400);

        // Reset mid-frame clears everything; next frame decodes.
        i_en = 1'b1;
        repeat (2) @(negedge i_clk);
        send_preamble();
        send_bits(16'h0005, 3);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_val("mid_rst_vld",  32'(o_frm_vld), 32'd0);
        check_val("mid_rst_data", 32'(o_frm_data), 32'd0);
        check_val("mid_rst_err",  32'(o_frm_err), 32'd0);
        check_val("mid_rst_busy", 32'(o_busy), 32'd0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        send_preamble();
        send_bits(16'h1234, 16);
        sym(1'b1);
        expect_frame("post_rst", 16'h1234, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
